// File: rtl/ps2_numeric_entry_pkg.sv
`default_nettype none
// ============================================================================
//  Module  : ps2_numeric_entry_pkg
//  Purpose : Shared PS/2 Set-2 scancode constants, prefix FSM state type and a
//            digit-decode helper. The keyboard datapath rework imports the
//            same package, so the scancode table is kept in one place.
//  Contents: SC_* scancode localparams, top-row/keypad digit tables,
//            prefix_state_t, digit_dec_t, decode_digit()
//  Revision: 1.0  initial release
// ============================================================================
package ps2_numeric_entry_pkg;

    localparam logic [7:0] SC_BREAK = 8'hF0;
    localparam logic [7:0] SC_EXT   = 8'hE0;
    localparam logic [7:0] SC_ENTER = 8'h5A;
    localparam logic [7:0] SC_BKSP  = 8'h66;
    localparam logic [7:0] SC_ESC   = 8'h76;

    // Index i of each table holds the make code for digit i.
    localparam logic [0:9][7:0] SC_TOP_ROW = {
        8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46
    };
    localparam logic [0:9][7:0] SC_KEYPAD = {
        8'h70, 8'h69, 8'h72, 8'h7A, 8'h6B, 8'h73, 8'h74, 8'h6C, 8'h75, 8'h7D
    };

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_BRK     = 2'd1,
        ST_EXT     = 2'd2,
        ST_EXT_BRK = 2'd3
    } prefix_state_t;

    typedef struct packed {
        logic       valid;
        logic [3:0] digit;
    } digit_dec_t;

    function automatic digit_dec_t decode_digit(input logic [7:0] code);
        digit_dec_t res;
        res.valid = 1'b0;
        res.digit = 4'd0;
        for (int i = 0; i < 10; i++) begin
            if (code == SC_TOP_ROW[i] || code == SC_KEYPAD[i]) begin
                res.valid = 1'b1;
                res.digit = 4'(i);
            end
        end
        return res;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ps2_numeric_entry_make_filter.sv
`default_nettype none
// ============================================================================
//  Module  : ps2_make_filter
//  Purpose : Prefix FSM that strips break (F0) and extended (E0) sequences
//            from a PS/2 Set-2 byte stream and emits registered make codes.
//            Extended make codes are discarded except keypad Enter (E0 5A),
//            which is passed through with make_ext set.
//  Ports   : clk, rst          clock / async active-high reset
//            data, data_en     scancode byte and its 1-cycle strobe
//            make_code         last accepted make code
//            make_en           1-cycle strobe: make_code valid
//            make_ext          make code came from an E0 prefix
//  Revision: 1.0  initial release
// ============================================================================
module ps2_make_filter
    import ps2_numeric_entry_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] data,
    input  logic       data_en,
    output logic [7:0] make_code,
    output logic       make_en,
    output logic       make_ext
);

    prefix_state_t state, state_next;
    logic [7:0]    code_next;
    logic          en_next;
    logic          ext_next;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            make_code <= 8'h00;
            make_en   <= 1'b0;
            make_ext  <= 1'b0;
        end else begin
            state     <= state_next;
            make_code <= code_next;
            make_en   <= en_next;
            make_ext  <= ext_next;
        end
    end

    always_comb begin
        state_next = state;
        code_next  = make_code;
        en_next    = 1'b0;
        ext_next   = 1'b0;
        if (data_en) begin
            code_next = data;
            case (state)
                ST_IDLE: begin
                    if (data == SC_BREAK)    state_next = ST_BRK;
                    else if (data == SC_EXT) state_next = ST_EXT;
                    else                     en_next    = 1'b1;
                end
                // A typematic F0 F0 keeps waiting for the released key.
                ST_BRK: begin
                    if (data != SC_BREAK) state_next = ST_IDLE;
                end
                ST_EXT: begin
                    if (data == SC_BREAK) begin
                        state_next = ST_EXT_BRK;
                    end else begin
                        state_next = ST_IDLE;
                        if (data == SC_ENTER) begin
                            en_next  = 1'b1;
                            ext_next = 1'b1;
                        end
                    end
                end
                ST_EXT_BRK: state_next = ST_IDLE;
                default:    state_next = ST_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/ps2_numeric_entry.sv
`default_nettype none
// ============================================================================
//  Module  : ps2_numeric_entry
//  Purpose : Numeric entry from a PS/2 keyboard. Buffers up to MAX_DIGITS
//            decimal digits (top row or keypad) with backspace/escape editing
//            and commits a saturated binary value on Enter.
//  Ports   : CLOCK_50, reset                 clock / async active-high reset
//            received_data, received_data_en scancode byte + strobe
//            value, value_valid, overflow    committed result, 1-cycle pulse,
//                                            saturation flag
//            digit_count, entry_bcd          live entry view ([3:0] newest)
//  Revision: 1.0  initial release
// ============================================================================
module ps2_numeric_entry
    import ps2_numeric_entry_pkg::*;
#(
    parameter int MAX_DIGITS = 3,
    parameter int OUT_WIDTH  = 8,
    parameter int MAX_VALUE  = 255
) (
    input  logic                    CLOCK_50,
    input  logic                    reset,
    input  logic [7:0]              received_data,
    input  logic                    received_data_en,
    output logic [OUT_WIDTH-1:0]    value,
    output logic                    value_valid,
    output logic                    overflow,
    output logic [2:0]              digit_count,
    output logic [4*MAX_DIGITS-1:0] entry_bcd
);

    localparam int                   BCD_W    = 4 * MAX_DIGITS;
    localparam logic [13:0]          MAX_BIN  = 14'(MAX_VALUE);
    localparam logic [OUT_WIDTH-1:0] MAX_OUT  = OUT_WIDTH'(MAX_VALUE);
    localparam logic [2:0]           MAX_CNT  = 3'(MAX_DIGITS);

    logic [7:0] make_code;
    logic       make_en;
    logic       make_ext;
    digit_dec_t dec;
    logic [13:0] bin;

    ps2_make_filter u_filter (
        .clk       (CLOCK_50),
        .rst       (reset),
        .data      (received_data),
        .data_en   (received_data_en),
        .make_code (make_code),
        .make_en   (make_en),
        .make_ext  (make_ext)
    );

    assign dec = decode_digit(make_code);

    // Positional BCD-to-binary; 14 bits covers 9999 for four digits.
    always_comb begin
        logic [13:0] weight;
        bin    = 14'd0;
        weight = 14'd1;
        for (int i = 0; i < MAX_DIGITS; i++) begin
            bin    = bin + 14'(entry_bcd[4*i +: 4]) * weight;
            weight = weight * 14'd10;
        end
    end

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            value       <= '0;
            value_valid <= 1'b0;
            overflow    <= 1'b0;
            digit_count <= 3'd0;
            entry_bcd   <= '0;
        end else begin
            value_valid <= 1'b0;
            if (make_en) begin
                // Extended codes reaching here are keypad Enter only.
                if (!make_ext && dec.valid) begin
                    if (digit_count < MAX_CNT) begin
                        entry_bcd   <= (entry_bcd << 4) | BCD_W'(dec.digit);
                        digit_count <= digit_count + 3'd1;
                    end
                end else if (!make_ext && make_code == SC_BKSP) begin
                    if (digit_count != 3'd0) begin
                        entry_bcd   <= entry_bcd >> 4;
                        digit_count <= digit_count - 3'd1;
                    end
                end else if (!make_ext && make_code == SC_ESC) begin
                    entry_bcd   <= '0;
                    digit_count <= 3'd0;
                end else if (make_code == SC_ENTER && digit_count != 3'd0) begin
                    value       <= (bin > MAX_BIN) ? MAX_OUT : OUT_WIDTH'(bin);
                    overflow    <= (bin > MAX_BIN);
                    value_valid <= 1'b1;
                    entry_bcd   <= '0;
                    digit_count <= 3'd0;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ps2_numeric_entry.sv
`default_nettype none
// ============================================================================
//  Module  : tb_ps2_numeric_entry
//  Purpose : Self-checking bench for ps2_numeric_entry: directed vector table,
//            hand-written timing/reset sequences and random byte streams
//            checked against a behavioural model.
//  Revision: 1.0  initial release
// ============================================================================
module tb_ps2_numeric_entry;

    logic        CLOCK_50 = 1'b0;
    logic        reset    = 1'b1;
    logic [7:0]  rx_data  = 8'h00;
    logic        rx_en    = 1'b0;
    logic [7:0]  value;
    logic        value_valid;
    logic        overflow;
    logic [2:0]  digit_count;
    logic [11:0] entry_bcd;

    int n_cmp  = 0;
    int n_fail = 0;
    int pulses = 0;

    ps2_numeric_entry #(.MAX_DIGITS(3), .OUT_WIDTH(8), .MAX_VALUE(255)) dut (
        .CLOCK_50         (CLOCK_50),
        .reset            (reset),
        .received_data    (rx_data),
        .received_data_en (rx_en),
        .value            (value),
        .value_valid      (value_valid),
        .overflow         (overflow),
        .digit_count      (digit_count),
        .entry_bcd        (entry_bcd)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    // Counts high samples, so a stretched pulse counts more than once.
    always @(negedge CLOCK_50) if (value_valid === 1'b1) pulses++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Called at a negedge; returns at the next negedge.
    task automatic strobe(input logic [7:0] b);
        rx_data = b;
        rx_en   = 1'b1;
        @(negedge CLOCK_50);
        rx_en   = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge CLOCK_50);
    endtask

    task automatic do_reset();
        @(negedge CLOCK_50);
        rx_en = 1'b0;
        reset = 1'b1;
        @(negedge CLOCK_50);
        reset = 1'b0;
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic [0:11][7:0] codes;
        int               len;
        logic [7:0]       exp_value;
        logic             exp_ovf;
        logic [2:0]       exp_cnt;
        logic [11:0]      exp_bcd;
        int               exp_pulses;
    } vec_t;

    vec_t vecs[$];

    task automatic add_vec(input logic [95:0] c, input int len, input logic [7:0] v,
                           input logic o, input logic [2:0] cnt, input logic [11:0] bcd,
                           input int p);
        vec_t t;
        t.codes = c; t.len = len; t.exp_value = v; t.exp_ovf = o;
        t.exp_cnt = cnt; t.exp_bcd = bcd; t.exp_pulses = p;
        vecs.push_back(t);
    endtask

    // ---------------- behavioural model ----------------
    int         m_digits[$];
    int         m_value;
    bit         m_ovf;
    bit         m_brk, m_ext, m_extbrk;
    int         m_pulse;
    logic [0:9][7:0] top_codes = {8'h45,8'h16,8'h1E,8'h26,8'h25,8'h2E,8'h36,8'h3D,8'h3E,8'h46};
    logic [0:9][7:0] kp_codes  = {8'h70,8'h69,8'h72,8'h7A,8'h6B,8'h73,8'h74,8'h6C,8'h75,8'h7D};

    function automatic int digit_of(input logic [7:0] b);
        for (int i = 0; i < 10; i++)
            if (b == top_codes[i] || b == kp_codes[i]) return i;
        return -1;
    endfunction

    task automatic m_commit();
        int n;
        if (m_digits.size() == 0) return;
        n = 0;
        foreach (m_digits[i]) n = n * 10 + m_digits[i];
        m_value = (n > 255) ? 255 : n;
        m_ovf   = (n > 255);
        m_pulse = 1;
        m_digits.delete();
    endtask

    task automatic m_byte(input logic [7:0] b);
        int d;
        m_pulse = 0;
        if (m_brk) begin
            if (b != 8'hF0) m_brk = 0;
        end else if (m_extbrk) begin
            m_extbrk = 0;
        end else if (m_ext) begin
            m_ext = 0;
            if (b == 8'hF0)      m_extbrk = 1;
            else if (b == 8'h5A) m_commit();
        end else if (b == 8'hF0) begin
            m_brk = 1;
        end else if (b == 8'hE0) begin
            m_ext = 1;
        end else begin
            d = digit_of(b);
            if (d >= 0) begin
                if (m_digits.size() < 3) m_digits.push_back(d);
            end else if (b == 8'h66) begin
                if (m_digits.size() > 0) void'(m_digits.pop_back());
            end else if (b == 8'h76) begin
                m_digits.delete();
            end else if (b == 8'h5A) begin
                m_commit();
            end
        end
    endtask

    function automatic logic [11:0] m_bcd();
        logic [11:0] r = 12'h0;
        foreach (m_digits[i]) r = (r << 4) | 12'(m_digits[i]);
        return r;
    endfunction

    logic [7:0] pool[$] = '{8'h45,8'h16,8'h1E,8'h26,8'h25,8'h2E,8'h36,8'h3D,8'h3E,8'h46,
                            8'h70,8'h69,8'h72,8'h7A,8'h6B,8'h73,8'h74,8'h6C,8'h75,8'h7D,
                            8'hF0,8'hE0,8'h5A,8'h5A,8'h5A,8'h66,8'h76,8'h12};

    initial begin
        int p0;
        logic [7:0] b;

        add_vec({8'h16,8'hF0,8'h16,8'h1E,8'hF0,8'h1E,8'h26,8'hF0,8'h26,8'h5A,16'h0}, 10, 8'd123, 0, 0, 12'h000, 1);
        add_vec({8'h46,8'h46,8'h46,8'h5A,64'h0}, 4, 8'd255, 1, 0, 12'h000, 1);
        add_vec({8'h46,8'h46,8'h46,8'h46,64'h0}, 4, 8'd0,   0, 3, 12'h999, 0);
        add_vec({8'h25,8'h2E,8'h66,8'h3D,8'hE0,8'h5A,48'h0}, 6, 8'd47, 0, 0, 12'h000, 1);
        add_vec({8'h25,8'h2E,8'hE0,8'h70,64'h0}, 4, 8'd0,   0, 2, 12'h045, 0);
        add_vec({8'h16,8'h5A,8'h5A,72'h0},       3, 8'd1,   0, 0, 12'h000, 1);
        add_vec({8'h16,8'h1E,8'h76,72'h0},       3, 8'd0,   0, 0, 12'h000, 0);
        add_vec({8'h66,8'h66,8'h69,8'h72,64'h0}, 4, 8'd0,   0, 2, 12'h012, 0);
        add_vec({8'hE0,8'hF0,8'h5A,8'h16,64'h0}, 4, 8'd0,   0, 1, 12'h001, 0);
        add_vec({8'hF0,8'hF0,8'h16,8'h1E,64'h0}, 4, 8'd0,   0, 1, 12'h002, 0);
        add_vec({8'h7D,8'h75,8'h6C,8'h5A,64'h0}, 4, 8'd255, 1, 0, 12'h000, 1);
        add_vec({8'h1E,8'h2E,8'h2E,8'h5A,64'h0}, 4, 8'd255, 0, 0, 12'h000, 1);
        add_vec({8'h1E,8'h2E,8'h36,8'h5A,64'h0}, 4, 8'd255, 1, 0, 12'h000, 1);

        // Reset state
        idle(2);
        reset = 1'b0;
        idle(1);
        chk("rst_value", 32'(value), 0);
        chk("rst_valid", 32'(value_valid), 0);
        chk("rst_ovf",   32'(overflow), 0);
        chk("rst_count", 32'(digit_count), 0);
        chk("rst_bcd",   32'(entry_bcd), 0);

        // Table: odd vectors are sent with an idle cycle between bytes.
        foreach (vecs[i]) begin
            do_reset();
            p0 = pulses;
            for (int j = 0; j < vecs[i].len; j++) begin
                strobe(vecs[i].codes[j]);
                if (i % 2 == 1) idle(1);
            end
            idle(3);
            chk($sformatf("vec%0d_value", i), 32'(value), 32'(vecs[i].exp_value));
            chk($sformatf("vec%0d_ovf", i),   32'(overflow), 32'(vecs[i].exp_ovf));
            chk($sformatf("vec%0d_count", i), 32'(digit_count), 32'(vecs[i].exp_cnt));
            chk($sformatf("vec%0d_bcd", i),   32'(entry_bcd), 32'(vecs[i].exp_bcd));
            chk($sformatf("vec%0d_pulses", i), 32'(pulses - p0), 32'(vecs[i].exp_pulses));
        end

        // Back-to-back strobes and exact pulse timing
        do_reset();
        p0 = pulses;
        strobe(8'h16);
        strobe(8'h1E);
        strobe(8'h5A);
        chk("b2b_valid_early", 32'(value_valid), 0);
        @(negedge CLOCK_50);
        chk("b2b_valid", 32'(value_valid), 1);
        chk("b2b_value", 32'(value), 12);
        chk("b2b_count", 32'(digit_count), 0);
        @(negedge CLOCK_50);
        chk("b2b_valid_late", 32'(value_valid), 0);
        chk("b2b_pulses", 32'(pulses - p0), 1);

        // Enter with empty buffer: no pulse, value holds
        p0 = pulses;
        strobe(8'h5A);
        idle(3);
        chk("empty_enter_value", 32'(value), 12);
        chk("empty_enter_pulses", 32'(pulses - p0), 0);

        // Asynchronous reset right after F0
        strobe(8'h1E);
        strobe(8'hF0);
        #2 reset = 1'b1;
        #1;
        chk("async_rst_value", 32'(value), 0);
        chk("async_rst_count", 32'(digit_count), 0);
        chk("async_rst_bcd",   32'(entry_bcd), 0);
        @(negedge CLOCK_50);
        reset = 1'b0;
        strobe(8'h16);
        idle(2);
        chk("post_rst_count", 32'(digit_count), 1);
        chk("post_rst_bcd",   32'(entry_bcd), 1);

        // Random stream against the model
        do_reset();
        m_digits.delete();
        m_value = 0; m_ovf = 0; m_brk = 0; m_ext = 0; m_extbrk = 0;
        for (int k = 0; k < 400; k++) begin
            if ($urandom_range(0, 19) == 0) b = 8'($urandom);
            else b = pool[$urandom_range(0, pool.size() - 1)];
            m_byte(b);
            p0 = pulses;
            strobe(b);
            idle(2);
            chk($sformatf("rnd%0d_value", k), 32'(value), 32'(m_value));
            chk($sformatf("rnd%0d_ovf", k),   32'(overflow), 32'(m_ovf));
            chk($sformatf("rnd%0d_count", k), 32'(digit_count), 32'(m_digits.size()));
            chk($sformatf("rnd%0d_bcd", k),   32'(entry_bcd), 32'(m_bcd()));
            chk($sformatf("rnd%0d_pulse", k), 32'(pulses - p0), 32'(m_pulse));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
